// File: rtl/ram_init_arb_pkg.sv
// Shared types for the RAM scrub-then-arbitrate block: controller states and requester ids.
package ram_init_arb_pkg;

    typedef enum logic {
        INIT = 1'b0,
        RUN  = 1'b1
    } state_e;

    typedef enum logic {
        HOST = 1'b0,
        DMA  = 1'b1
    } req_id_e;

endpackage

// File: rtl/ram_init_arb_if.sv
// Host, DMA and RAM-port bundles of ram_init_arb; names carry the arbiter's view of direction.
interface ram_init_arb_if #(
    parameter int unsigned Width = 32
);
    logic             h_req_i;
    logic             h_we_i;
    logic [3:0]       h_be_i;
    logic [31:0]      h_addr_i;
    logic [Width-1:0] h_wdata_i;
    logic             h_gnt_o;
    logic             h_rvalid_o;
    logic [Width-1:0] h_rdata_o;

    logic             d_req_i;
    logic             d_we_i;
    logic [3:0]       d_be_i;
    logic [31:0]      d_addr_i;
    logic [Width-1:0] d_wdata_i;
    logic             d_gnt_o;
    logic             d_rvalid_o;
    logic [Width-1:0] d_rdata_o;

    logic             ram_req_o;
    logic             ram_we_o;
    logic [3:0]       ram_be_o;
    logic [31:0]      ram_addr_o;
    logic [Width-1:0] ram_wdata_o;
    logic             ram_rvalid_i;
    logic [Width-1:0] ram_rdata_i;

    modport slave (
        input  h_req_i, h_we_i, h_be_i, h_addr_i, h_wdata_i,
        input  d_req_i, d_we_i, d_be_i, d_addr_i, d_wdata_i,
        input  ram_rvalid_i, ram_rdata_i,
        output h_gnt_o, h_rvalid_o, h_rdata_o,
        output d_gnt_o, d_rvalid_o, d_rdata_o,
        output ram_req_o, ram_we_o, ram_be_o, ram_addr_o, ram_wdata_o
    );

    modport master (
        output h_req_i, h_we_i, h_be_i, h_addr_i, h_wdata_i,
        output d_req_i, d_we_i, d_be_i, d_addr_i, d_wdata_i,
        output ram_rvalid_i, ram_rdata_i,
        input  h_gnt_o, h_rvalid_o, h_rdata_o,
        input  d_gnt_o, d_rvalid_o, d_rdata_o,
        input  ram_req_o, ram_we_o, ram_be_o, ram_addr_o, ram_wdata_o
    );
endinterface

// File: rtl/ram_init_arb_rr.sv
// Two-way round-robin grant: combinational grant, pointer moves to the loser on contention only.
module ram_init_arb_rr
    import ram_init_arb_pkg::*;
(
    input  logic clk_i,
    input  logic rst_ni,
    input  logic en_i,
    input  logic h_req_i,
    input  logic d_req_i,
    output logic h_gnt_o,
    output logic d_gnt_o
);

    req_id_e rr_q, rr_d;

    always_comb begin
        h_gnt_o = 1'b0;
        d_gnt_o = 1'b0;
        rr_d    = rr_q;
        if (en_i) begin
            if (h_req_i && d_req_i) begin
                if (rr_q == HOST) begin
                    h_gnt_o = 1'b1;
                    rr_d    = DMA;
                end else begin
                    d_gnt_o = 1'b1;
                    rr_d    = HOST;
                end
            end else begin
                h_gnt_o = h_req_i;
                d_gnt_o = d_req_i;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rr_q <= HOST;
        end else begin
            rr_q <= rr_d;
        end
    end

endmodule

// File: rtl/ram_init_arb.sv
// Zero-scrubs the RAM after reset or on request, then arbitrates host/DMA onto the single RAM port.
module ram_init_arb
    import ram_init_arb_pkg::*;
#(
    parameter int unsigned Depth      = 128,
    parameter int unsigned Width      = 32,
    parameter int unsigned AddrOffset = 2
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic init_req_i,
    output logic init_done_o,
    ram_init_arb_if.slave bus
);

    localparam int unsigned      CntW      = $clog2(Depth);
    localparam logic [CntW-1:0]  CntLast   = CntW'(Depth - 1);
    localparam logic [Width-1:0] ScrubData = '0;

    state_e          state_q, state_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic            init_done_q, init_done_d;
    req_id_e         owner_q, owner_d;
    logic            owner_vld_q, owner_vld_d;
    logic            run, h_gnt, d_gnt, rd_gnt;

    assign run = (state_q == RUN);

    ram_init_arb_rr u_rr (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .en_i    (run),
        .h_req_i (bus.h_req_i),
        .d_req_i (bus.d_req_i),
        .h_gnt_o (h_gnt),
        .d_gnt_o (d_gnt)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            INIT: begin
                if (cnt_q == CntLast) begin
                    state_d = RUN;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            RUN: begin
                if (init_req_i) begin
                    state_d = INIT;
                    cnt_d   = '0;
                end
            end
        endcase
        init_done_d = (state_d == RUN);

        // Owner is tracked across the RUN->INIT edge so a last-cycle read still returns.
        rd_gnt      = (h_gnt && !bus.h_we_i) || (d_gnt && !bus.d_we_i);
        owner_vld_d = rd_gnt;
        owner_d     = owner_q;
        if (rd_gnt) begin
            owner_d = d_gnt ? DMA : HOST;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= INIT;
            cnt_q       <= '0;
            init_done_q <= 1'b0;
            owner_q     <= HOST;
            owner_vld_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            init_done_q <= init_done_d;
            owner_q     <= owner_d;
            owner_vld_q <= owner_vld_d;
        end
    end

    always_comb begin
        bus.ram_req_o   = 1'b0;
        bus.ram_we_o    = 1'b0;
        bus.ram_be_o    = '0;
        bus.ram_addr_o  = '0;
        bus.ram_wdata_o = '0;
        if (!run) begin
            bus.ram_req_o   = 1'b1;
            bus.ram_we_o    = 1'b1;
            bus.ram_be_o    = '1;
            bus.ram_addr_o  = 32'(cnt_q) << AddrOffset;
            bus.ram_wdata_o = ScrubData;
        end else if (h_gnt) begin
            bus.ram_req_o   = 1'b1;
            bus.ram_we_o    = bus.h_we_i;
            bus.ram_be_o    = bus.h_be_i;
            bus.ram_addr_o  = bus.h_addr_i;
            bus.ram_wdata_o = bus.h_wdata_i;
        end else if (d_gnt) begin
            bus.ram_req_o   = 1'b1;
            bus.ram_we_o    = bus.d_we_i;
            bus.ram_be_o    = bus.d_be_i;
            bus.ram_addr_o  = bus.d_addr_i;
            bus.ram_wdata_o = bus.d_wdata_i;
        end
    end

    assign bus.h_gnt_o    = h_gnt;
    assign bus.d_gnt_o    = d_gnt;
    assign bus.h_rvalid_o = bus.ram_rvalid_i && owner_vld_q && (owner_q == HOST);
    assign bus.d_rvalid_o = bus.ram_rvalid_i && owner_vld_q && (owner_q == DMA);
    assign bus.h_rdata_o  = bus.ram_rdata_i;
    assign bus.d_rdata_o  = bus.ram_rdata_i;
    assign init_done_o    = init_done_q;

    a_one_gnt: assert property (@(posedge clk_i) disable iff (!rst_ni)
        !(bus.h_gnt_o && bus.d_gnt_o));
    a_one_rvalid: assert property (@(posedge clk_i) disable iff (!rst_ni)
        !(bus.h_rvalid_o && bus.d_rvalid_o));
    a_no_gnt_in_init: assert property (@(posedge clk_i) disable iff (!rst_ni)
        !init_done_o |-> !(bus.h_gnt_o || bus.d_gnt_o));

endmodule

// File: tb/tb_ram_init_arb.sv
// Randomized bench for ram_init_arb against a cycle-level behavioural model of scrub, arbitration and responses.
module tb_ram_init_arb;

    localparam int unsigned DEPTH = 128;

    logic clk_i = 1'b0;
    logic rst_ni = 1'b0;
    logic init_req_i = 1'b0;
    logic init_done_o;

    ram_init_arb_if #(.Width(32)) bus();

    ram_init_arb #(.Depth(DEPTH), .Width(32), .AddrOffset(2)) dut (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .init_req_i  (init_req_i),
        .init_done_o (init_done_o),
        .bus         (bus)
    );

    always #5 clk_i = ~clk_i;

    logic        h_req = 1'b0, h_we = 1'b0, d_req = 1'b0, d_we = 1'b0;
    logic [3:0]  h_be = '0, d_be = '0;
    logic [31:0] h_addr = '0, h_wd = '0, d_addr = '0, d_wd = '0;
    logic        inject_rv = 1'b0;

    assign bus.h_req_i   = h_req;
    assign bus.h_we_i    = h_we;
    assign bus.h_be_i    = h_be;
    assign bus.h_addr_i  = h_addr;
    assign bus.h_wdata_i = h_wd;
    assign bus.d_req_i   = d_req;
    assign bus.d_we_i    = d_we;
    assign bus.d_be_i    = d_be;
    assign bus.d_addr_i  = d_addr;
    assign bus.d_wdata_i = d_wd;

    function automatic logic [31:0] be_mask(input logic [3:0] be);
        return {{8{be[3]}}, {8{be[2]}}, {8{be[1]}}, {8{be[0]}}};
    endfunction

    // RAM environment: one-cycle read latency, ignores the port while reset is asserted.
    logic [31:0] ram [DEPTH];
    always @(posedge clk_i) begin
        bus.ram_rvalid_i <= inject_rv;
        if (rst_ni && bus.ram_req_o) begin
            if (bus.ram_we_o) begin
                ram[bus.ram_addr_o[8:2]] <= (ram[bus.ram_addr_o[8:2]] & ~be_mask(bus.ram_be_o))
                                          | (bus.ram_wdata_o & be_mask(bus.ram_be_o));
            end else begin
                bus.ram_rdata_i  <= ram[bus.ram_addr_o[8:2]];
                bus.ram_rvalid_i <= 1'b1;
            end
        end
    end

    int total = 0;
    int bad = 0;

    bit          scrubbing;
    int          scrub_word;
    int          rr_pref;
    bit          pend_v;
    int          pend_own;
    logic [31:0] pend_data;
    logic [31:0] exp_mem [DEPTH];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] want);
        total++;
        assert (obs === want) else begin
            bad++;
            $error("FAIL %s: got %h want %h", tag, obs, want);
        end
    endtask

    task automatic model_reset();
        scrubbing  = 1'b1;
        scrub_word = 0;
        rr_pref    = 0;
        pend_v     = 1'b0;
    endtask

    task automatic randomize_bundles();
        h_req  = 1'($urandom_range(0, 1));
        h_we   = 1'($urandom_range(0, 1));
        h_be   = 4'($urandom_range(0, 15));
        h_addr = {23'd0, 7'($urandom_range(0, DEPTH - 1)), 2'b00};
        h_wd   = $urandom;
        d_req  = 1'($urandom_range(0, 1));
        d_we   = 1'($urandom_range(0, 1));
        d_be   = 4'($urandom_range(0, 15));
        d_addr = {23'd0, 7'($urandom_range(0, DEPTH - 1)), 2'b00};
        d_wd   = $urandom;
    endtask

    // Called just after a falling edge with inputs settled; returns at the next falling edge.
    task automatic step();
        int          win;
        bit          contended;
        logic        ewe;
        logic [3:0]  ebe;
        logic [31:0] ea, ewd;
        int          idx;
        #1;
        win = -1;
        contended = 1'b0;
        if (scrubbing) begin
            ewe = 1'b1; ebe = 4'hF; ea = 32'(scrub_word * 4); ewd = '0;
        end else begin
            if (h_req && d_req) begin
                win = rr_pref;
                contended = 1'b1;
            end else if (h_req) begin
                win = 0;
            end else if (d_req) begin
                win = 1;
            end
            ewe = (win == 0) ? h_we : d_we;
            ebe = (win == 0) ? h_be : d_be;
            ea  = (win == 0) ? h_addr : d_addr;
            ewd = (win == 0) ? h_wd : d_wd;
        end
        chk("init_done", 32'(init_done_o), 32'(!scrubbing));
        chk("h_gnt", 32'(bus.h_gnt_o), 32'(win == 0));
        chk("d_gnt", 32'(bus.d_gnt_o), 32'(win == 1));
        chk("ram_req", 32'(bus.ram_req_o), 32'(scrubbing || win >= 0));
        if (scrubbing || win >= 0) begin
            chk("ram_we", 32'(bus.ram_we_o), 32'(ewe));
            chk("ram_be", 32'(bus.ram_be_o), 32'(ebe));
            chk("ram_addr", bus.ram_addr_o, ea);
            if (ewe) chk("ram_wdata", bus.ram_wdata_o, ewd);
        end
        chk("h_rvalid", 32'(bus.h_rvalid_o), 32'(pend_v && pend_own == 0));
        chk("d_rvalid", 32'(bus.d_rvalid_o), 32'(pend_v && pend_own == 1));
        if (pend_v) begin
            chk("h_rdata", bus.h_rdata_o, pend_data);
            chk("d_rdata", bus.d_rdata_o, pend_data);
        end

        @(posedge clk_i);
        pend_v = 1'b0;
        if (scrubbing) begin
            exp_mem[scrub_word] = '0;
            scrub_word++;
            if (scrub_word == DEPTH) scrubbing = 1'b0;
        end else begin
            if (win >= 0) begin
                idx = int'(ea[8:2]);
                if (ewe) begin
                    exp_mem[idx] = (exp_mem[idx] & ~be_mask(ebe)) | (ewd & be_mask(ebe));
                end else begin
                    pend_v    = 1'b1;
                    pend_own  = win;
                    pend_data = exp_mem[idx];
                end
            end
            if (contended) rr_pref = 1 - win;
            if (init_req_i) begin
                scrubbing  = 1'b1;
                scrub_word = 0;
            end
        end
        @(negedge clk_i);
    endtask

    task automatic idle();
        h_req = 1'b0; d_req = 1'b0; init_req_i = 1'b0; inject_rv = 1'b0;
    endtask

    task automatic reset_checks();
        #1;
        chk("rst_init_done", 32'(init_done_o), 32'd0);
        chk("rst_h_gnt", 32'(bus.h_gnt_o), 32'd0);
        chk("rst_d_gnt", 32'(bus.d_gnt_o), 32'd0);
        chk("rst_h_rvalid", 32'(bus.h_rvalid_o), 32'd0);
        chk("rst_d_rvalid", 32'(bus.d_rvalid_o), 32'd0);
        chk("rst_ram_req", 32'(bus.ram_req_o), 32'd1);
        chk("rst_ram_addr", bus.ram_addr_o, 32'd0);
    endtask

    initial begin
        h_req = 1'b1; d_req = 1'b1;
        rst_ni = 1'b0;
        @(negedge clk_i);
        reset_checks();
        @(negedge clk_i);
        rst_ni = 1'b1;
        model_reset();

        // Initial scrub with traffic and ignored re-scrub requests.
        repeat (DEPTH) begin
            randomize_bundles();
            init_req_i = 1'($urandom_range(0, 1));
            step();
        end
        idle();
        step();

        // DMA writes a known word, host reads it back.
        d_req = 1'b1; d_we = 1'b1; d_be = 4'hF; d_addr = 32'h10; d_wd = 32'hDEADBEEF;
        step();
        idle();
        h_req = 1'b1; h_we = 1'b0; h_addr = 32'h10;
        step();
        idle();
        step();

        // Continuous contention from the reset pointer, then DMA alone, then contention.
        repeat (4) begin
            randomize_bundles();
            h_req = 1'b1; d_req = 1'b1;
            step();
        end
        repeat (3) begin
            randomize_bundles();
            h_req = 1'b0; d_req = 1'b1;
            step();
        end
        randomize_bundles();
        h_req = 1'b1; d_req = 1'b1;
        step();

        // Host read in the same cycle a re-scrub is requested.
        idle();
        h_req = 1'b1; h_we = 1'b0; h_addr = 32'h20;
        init_req_i = 1'b1;
        step();
        idle();
        repeat (DEPTH + 1) step();

        // Re-scrub interrupted by reset at word 60.
        init_req_i = 1'b1;
        step();
        idle();
        repeat (59) step();
        inject_rv = 1'b1;
        step();
        inject_rv = 1'b0;
        rst_ni = 1'b0;
        reset_checks();
        @(negedge clk_i);
        rst_ni = 1'b1;
        model_reset();
        repeat (DEPTH + 2) step();

        // Random traffic with occasional re-scrubs and stray RAM responses.
        repeat (3000) begin
            randomize_bundles();
            init_req_i = ($urandom_range(0, 99) == 0);
            inject_rv  = ($urandom_range(0, 7) == 0);
            step();
        end
        idle();
        step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/ram_init_arb.md
RAM_INIT_ARB -- requirements
Module: ram_init_arb

Interface
REQ-001 Parameter Depth, default 128: number of RAM words to scrub; any value >= 2.
REQ-002 Parameter Width, default 32: data width.
REQ-003 Parameter AddrOffset, default 2: word-index bit offset in byte addresses.
REQ-004 clk_i  input  1  clock; all logic on rising edge.
REQ-005 rst_ni  input  1  reset, asynchronous, active-low.
REQ-006 init_req_i  input  1  request a re-scrub of the whole RAM.
REQ-007 init_done_o  output  1  high while scrub is complete and requesters are served.
REQ-008 h_req_i, h_we_i, h_be_i[3:0], h_addr_i[31:0], h_wdata_i[Width]  input  host request bundle.
REQ-009 h_gnt_o  output  1  host request accepted this cycle.
REQ-010 h_rvalid_o  output  1 / h_rdata_o  output  Width  host read response.
REQ-011 d_req_i, d_we_i, d_be_i[3:0], d_addr_i[31:0], d_wdata_i[Width]  input  DMA request bundle.
REQ-012 d_gnt_o  output  1 / d_rvalid_o  output  1 / d_rdata_o  output  Width  DMA grant and response.
REQ-013 ram_req_o, ram_we_o, ram_be_o[3:0], ram_addr_o[31:0], ram_wdata_o[Width]  output  single RAM port drive.
REQ-014 ram_rvalid_i  input  1 / ram_rdata_i  input  Width  RAM response; exactly 1 cycle after an accepted read.

Function
REQ-015 FSM states SHALL be INIT and RUN only.
REQ-016 INIT: ram_req_o=1, ram_we_o=1, ram_be_o=4'hF, ram_wdata_o=0, ram_addr_o=cnt<<AddrOffset (zero-extended); h_gnt_o=d_gnt_o=0.
REQ-017 INIT: cnt (width $clog2(Depth)) SHALL increment by 1 every cycle; at cnt==Depth-1, next state RUN and cnt clears to 0.
REQ-018 init_done_o SHALL be registered: 1 exactly when state==RUN.
REQ-019 RUN with init_req_i=1: next state INIT, cnt=0; this cycle's request still arbitrated normally.
REQ-020 init_req_i SHALL be ignored while in INIT (scrub not restarted).
REQ-021 RUN: grant combinational, same cycle as request; at most one grant per cycle; no request -> ram_req_o=0.
REQ-022 Single requester active: that requester SHALL be granted.
REQ-023 Both active: grant the requester indicated by round-robin pointer rr; after a contended grant rr SHALL point to the loser.
REQ-024 Uncontended grants SHALL leave rr unchanged.
REQ-025 Granted requester's bundle SHALL drive ram_* outputs unmodified.
REQ-026 On a granted read (we=0) an owner flag SHALL be registered; ram_rvalid_i next cycle SHALL assert only that owner's rvalid.
REQ-027 h_rdata_o and d_rdata_o SHALL both equal ram_rdata_i (broadcast); only rvalid is routed.
REQ-028 A read granted in the last RUN cycle before INIT SHALL still return to its owner during INIT.
REQ-029 Writes produce no rvalid; no backpressure exists beyond grant.
REQ-030 ram_rvalid_i without a prior granted read SHALL be dropped (neither rvalid asserted).

Reset
REQ-031 On rst_ni low: state=INIT, cnt=0, rr=host, owner=host, owner-valid=0, init_done_o=0.
REQ-032 Reset release SHALL start a full scrub from word 0; asserting reset mid-scrub restarts the scrub from word 0 on release.
REQ-033 During reset all grants and rvalids SHALL be 0; ram_req_o follows INIT encoding (combinational) but is ignored by the RAM while in reset.

Structure
REQ-034 Package ram_init_arb_pkg SHALL hold the state enum (INIT, RUN) and the requester-id typedef (HOST=0, DMA=1).
REQ-035 The 2-way round-robin grant logic with rr pointer SHALL be sub-module ram_init_arb_rr; FSM, counter and response routing live in the top.
REQ-036 Assertions: h_gnt_o & d_gnt_o never both 1; rvalid outputs mutually exclusive; no grant while init_done_o=0.

Verification
REQ-037 Reset release, Depth=128 -> 128 consecutive zero writes to addresses 0x000..0x1FC, init_done_o=1 at cycle 129 after release.
REQ-038 RUN, host read addr 0x10 with RAM holding 0xDEADBEEF -> h_gnt_o same cycle, h_rvalid_o=1 with h_rdata_o=0xDEADBEEF next cycle, d_rvalid_o=0.
REQ-039 Both requesting continuously for 4 cycles from reset rr -> grants H,D,H,D.
REQ-040 Host read granted in the same cycle as init_req_i=1 -> h_rvalid_o next cycle while scrub writes address 0x000; init_done_o low for 128 cycles.
REQ-041 rst_ni pulsed low at scrub word 60 -> after release the scrub restarts at address 0x000 and spans 128 words.
REQ-042 Only DMA requesting for 3 cycles, then both -> three D grants, then H granted (rr unchanged by uncontended grants).
